// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// mem_access_ctrl_if: CPU-side request/response bus of mem_access_ctrl.
// Rev 1.0
interface mem_access_ctrl_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic                  req_sz;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [15:0]           req_wdata;
  logic                  resp_valid;
  logic                  resp_err;
  logic [15:0]           resp_rdata;

  modport master (
    output req_valid, req_write, req_sz, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_sz, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// mem_access_ctrl: single-outstanding CPU transaction controller for the test memory,
// with watchdog timeout and a guaranteed request-low gap. Rev 1.0
module mem_access_ctrl #(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mem_access_ctrl_if.slave      cpu,
  output logic                  mem_req_rdwr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_data_acc_sz,
  output logic [7:0]            mem_wdata_8,
  output logic [15:0]           mem_wdata_16,
  output logic                  mem_we_8,
  output logic                  mem_we_16,
  input  logic [7:0]            mem_rdata_8,
  input  logic [15:0]           mem_rdata_16,
  input  logic                  mem_data_ready
);
  // Size encoding of pkg_cpu: cpu_data_acc_sz_8 = 0, cpu_data_acc_sz_16 = 1.
  localparam logic       SZ_16        = 1'b1;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    IDLE   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t     state;
  logic       rst_sync;
  logic       write_q;
  logic [7:0] count;

  // Reset asserts asynchronously; release is seen by the FSM one edge later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 1'b0;
    else          rst_sync <= 1'b1;
  end

  assign mem_wdata_8 = mem_wdata_16[7:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= SETTLE;
      cpu.req_ready   <= 1'b0;
      cpu.resp_valid  <= 1'b0;
      cpu.resp_err    <= 1'b0;
      cpu.resp_rdata  <= '0;
      mem_req_rdwr    <= 1'b0;
      mem_addr        <= '0;
      mem_data_acc_sz <= 1'b0;
      mem_wdata_16    <= '0;
      mem_we_8        <= 1'b0;
      mem_we_16       <= 1'b0;
      write_q         <= 1'b0;
      count           <= '0;
    end else if (rst_sync) begin
      unique case (state)
        SETTLE: begin
          cpu.req_ready <= 1'b1;
          state         <= IDLE;
        end
        IDLE: begin
          if (cpu.req_valid) begin
            write_q         <= cpu.req_write;
            mem_addr        <= cpu.req_addr;
            mem_data_acc_sz <= cpu.req_sz;
            mem_wdata_16    <= cpu.req_wdata;
            mem_we_8        <= cpu.req_write & (cpu.req_sz != SZ_16);
            mem_we_16       <= cpu.req_write & (cpu.req_sz == SZ_16);
            mem_req_rdwr    <= 1'b1;
            cpu.req_ready   <= 1'b0;
            count           <= '0;
            state           <= ACCESS;
          end
        end
        ACCESS: begin
          // Ready is checked first so it wins over a coincident timeout.
          if (mem_data_ready) begin
            cpu.resp_valid <= 1'b1;
            cpu.resp_err   <= 1'b0;
            if (write_q)                       cpu.resp_rdata <= '0;
            else if (mem_data_acc_sz == SZ_16) cpu.resp_rdata <= mem_rdata_16;
            else                               cpu.resp_rdata <= {8'h00, mem_rdata_8};
            mem_req_rdwr <= 1'b0;
            mem_we_8     <= 1'b0;
            mem_we_16    <= 1'b0;
            state        <= RESP;
          end else if (count == TIMEOUT_LAST) begin
            cpu.resp_valid <= 1'b1;
            cpu.resp_err   <= 1'b1;
            cpu.resp_rdata <= '0;
            mem_req_rdwr   <= 1'b0;
            mem_we_8       <= 1'b0;
            mem_we_16      <= 1'b0;
            state          <= RESP;
          end else begin
            count <= count + 8'd1;
          end
        end
        RESP: begin
          cpu.resp_valid <= 1'b0;
          cpu.resp_err   <= 1'b0;
          cpu.resp_rdata <= '0;
          state          <= SETTLE;
        end
        default: state <= SETTLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// tb_mem_access_ctrl: directed self-checking bench with a behavioural phase-delay memory.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_req_rdwr;
  logic [15:0] mem_addr;
  logic        mem_data_acc_sz;
  logic [7:0]  mem_wdata_8;
  logic [15:0] mem_wdata_16;
  logic        mem_we_8;
  logic        mem_we_16;
  logic [7:0]  mem_rdata_8;
  logic [15:0] mem_rdata_16;
  logic        mem_data_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // memory model controls: ready latency (1 or 2 edges) and a stuck-not-ready stub
  int   mem_delay = 1;
  bit   tie_low = 1'b0;
  int   seen = 0;
  logic [7:0]  mem [0:65535];
  logic [15:0] addr_p1;

  // transaction results
  int         t_lat, t_acc, t_we8, t_we16;
  logic [15:0] t_rdata;
  logic       t_err, t_again;
  logic [2:0] t_strobes;

  mem_access_ctrl_if #(.ADDR_WIDTH(16)) cpu ();

  mem_access_ctrl #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(15)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cpu            (cpu),
    .mem_req_rdwr   (mem_req_rdwr),
    .mem_addr       (mem_addr),
    .mem_data_acc_sz(mem_data_acc_sz),
    .mem_wdata_8    (mem_wdata_8),
    .mem_wdata_16   (mem_wdata_16),
    .mem_we_8       (mem_we_8),
    .mem_we_16      (mem_we_16),
    .mem_rdata_8    (mem_rdata_8),
    .mem_rdata_16   (mem_rdata_16),
    .mem_data_ready (mem_data_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign addr_p1 = mem_addr + 16'd1;

  initial begin
    mem_data_ready = 1'b0;
    mem_rdata_8    = 8'h00;
    mem_rdata_16   = 16'h0000;
  end

  always @(posedge clk) begin
    if (!mem_req_rdwr || tie_low) begin
      seen           <= 0;
      mem_data_ready <= 1'b0;
    end else begin
      seen <= seen + 1;
      if (seen + 1 >= mem_delay) begin
        mem_data_ready <= 1'b1;
        mem_rdata_8    <= mem[mem_addr];
        mem_rdata_16   <= {mem[mem_addr], mem[addr_p1]};
      end
    end
    if (mem_we_16) begin
      mem[mem_addr] <= mem_wdata_16[15:8];
      mem[addr_p1]  <= mem_wdata_16[7:0];
    end
    if (mem_we_8) mem[mem_addr] <= mem_wdata_8;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Issue one request (called at a negedge) and gather what the DUT returns.
  task automatic run_txn(input logic wr, input logic sz, input logic [15:0] addr,
                         input logic [15:0] wdata);
    int n;
    t_lat = -1; t_acc = 0; t_we8 = 0; t_we16 = 0;
    t_rdata = 16'hDEAD; t_err = 1'bx; t_again = 1'b0; t_strobes = 3'b111;
    cpu.req_write = wr; cpu.req_sz = sz; cpu.req_addr = addr; cpu.req_wdata = wdata;
    cpu.req_valid = 1'b1;
    n = 0;
    while (cpu.req_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (cpu.req_ready !== 1'b1) begin
      cpu.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    cpu.req_valid = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (cpu.resp_valid === 1'b1) begin
        t_lat = k;
        break;
      end
      if (mem_req_rdwr) begin
        t_acc++;
        if (mem_we_8)  t_we8++;
        if (mem_we_16) t_we16++;
      end
      @(negedge clk);
    end
    if (t_lat >= 0) begin
      t_rdata   = cpu.resp_rdata;
      t_err     = cpu.resp_err;
      t_strobes = {mem_req_rdwr, mem_we_8, mem_we_16};
      @(negedge clk);
      t_again = cpu.resp_valid;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cpu.req_valid = 1'b0; cpu.req_write = 1'b0; cpu.req_sz = 1'b0;
    cpu.req_addr = '0; cpu.req_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cpu.req_ready, cpu.resp_valid, cpu.resp_err, mem_req_rdwr, mem_we_8, mem_we_16} !== 6'b0)
      begin errors++; $display("FAIL reset_ctrl got %b exp 000000",
        {cpu.req_ready, cpu.resp_valid, cpu.resp_err, mem_req_rdwr, mem_we_8, mem_we_16}); end
    checks++;
    if (mem_addr !== 16'h0 || cpu.resp_rdata !== 16'h0 || mem_wdata_16 !== 16'h0)
      begin errors++; $display("FAIL reset_data got addr %h rdata %h wdata %h exp 0",
        mem_addr, cpu.resp_rdata, mem_wdata_16); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu.req_ready !== 1'b0)
      begin errors++; $display("FAIL ready_edge1 got %b exp 0", cpu.req_ready); end
    @(negedge clk);
    checks++;
    if (cpu.req_ready !== 1'b1)
      begin errors++; $display("FAIL ready_edge2 got %b exp 1", cpu.req_ready); end
  endtask

  task automatic test_read8();
    mem_delay = 1;
    run_txn(1'b0, 1'b0, 16'h0010, 16'h0000);
    checks++;
    if (t_lat != 2) begin errors++; $display("FAIL read8_lat_d1 got %0d exp 2", t_lat); end
    checks++;
    if (t_rdata !== 16'h00A5 || t_err !== 1'b0)
      begin errors++; $display("FAIL read8_d1 got %h err %b exp 00a5 err 0", t_rdata, t_err); end
    checks++;
    if (t_again !== 1'b0) begin errors++; $display("FAIL read8_pulse got %b exp 0", t_again); end
    mem_delay = 2;
    run_txn(1'b0, 1'b0, 16'h0010, 16'h0000);
    checks++;
    if (t_lat != 3) begin errors++; $display("FAIL read8_lat_d2 got %0d exp 3", t_lat); end
    checks++;
    if (t_rdata !== 16'h00A5 || t_err !== 1'b0)
      begin errors++; $display("FAIL read8_d2 got %h err %b exp 00a5 err 0", t_rdata, t_err); end
  endtask

  task automatic test_write16_read();
    mem_delay = 2;
    run_txn(1'b1, 1'b1, 16'h0020, 16'hBEEF);
    checks++;
    if (t_rdata !== 16'h0000 || t_err !== 1'b0 || t_lat != 3)
      begin errors++; $display("FAIL write16_resp got %h err %b lat %0d exp 0000 0 3", t_rdata, t_err, t_lat); end
    checks++;
    if (t_we16 != t_acc || t_we8 != 0 || t_acc == 0)
      begin errors++; $display("FAIL write16_we got we16 %0d we8 %0d acc %0d", t_we16, t_we8, t_acc); end
    mem_delay = 1;
    run_txn(1'b0, 1'b1, 16'h0020, 16'h0000);
    checks++;
    if (t_rdata !== 16'hBEEF) begin errors++; $display("FAIL read16_20 got %h exp beef", t_rdata); end
    run_txn(1'b0, 1'b0, 16'h0020, 16'h0000);
    checks++;
    if (t_rdata !== 16'h00BE) begin errors++; $display("FAIL read8_20 got %h exp 00be", t_rdata); end
    run_txn(1'b0, 1'b0, 16'h0021, 16'h0000);
    checks++;
    if (t_rdata !== 16'h00EF) begin errors++; $display("FAIL read8_21 got %h exp 00ef", t_rdata); end
  endtask

  task automatic test_write8();
    mem_delay = 2;
    run_txn(1'b1, 1'b0, 16'h0030, 16'h125A);
    checks++;
    if (t_we8 != t_acc || t_we16 != 0 || t_acc == 0)
      begin errors++; $display("FAIL write8_we got we8 %0d we16 %0d acc %0d", t_we8, t_we16, t_acc); end
    mem_delay = 1;
    run_txn(1'b0, 1'b0, 16'h0030, 16'h0000);
    checks++;
    if (t_rdata !== 16'h005A) begin errors++; $display("FAIL write8_rb30 got %h exp 005a", t_rdata); end
    run_txn(1'b0, 1'b0, 16'h0031, 16'h0000);
    checks++;
    if (t_rdata !== 16'h0077) begin errors++; $display("FAIL write8_rb31 got %h exp 0077", t_rdata); end
  endtask

  task automatic test_wrap();
    mem_delay = 1;
    run_txn(1'b1, 1'b1, 16'hFFFF, 16'h1234);
    run_txn(1'b0, 1'b1, 16'hFFFF, 16'h0000);
    checks++;
    if (t_rdata !== 16'h1234) begin errors++; $display("FAIL wrap_read16 got %h exp 1234", t_rdata); end
    run_txn(1'b0, 1'b0, 16'h0000, 16'h0000);
    checks++;
    if (t_rdata !== 16'h0034) begin errors++; $display("FAIL wrap_read8_0 got %h exp 0034", t_rdata); end
  endtask

  task automatic test_back_to_back();
    int nacc, nresp, low_run, min_low;
    int acc_cyc[4];
    bit seen_high, bad_data;
    nacc = 0; nresp = 0; low_run = 0; min_low = 1000; seen_high = 0; bad_data = 0;
    mem_delay = 1;
    cpu.req_write = 1'b0; cpu.req_sz = 1'b0; cpu.req_addr = 16'h0010; cpu.req_wdata = '0;
    cpu.req_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (nacc == 4) cpu.req_valid = 1'b0;
      if (cpu.req_valid && cpu.req_ready === 1'b1) begin
        acc_cyc[nacc] = cyc;
        nacc++;
      end
      if (cpu.resp_valid === 1'b1) begin
        nresp++;
        if (cpu.resp_rdata !== 16'h00A5 || cpu.resp_err !== 1'b0) bad_data = 1'b1;
      end
      if (mem_req_rdwr === 1'b1) begin
        if (seen_high && low_run > 0 && low_run < min_low) min_low = low_run;
        seen_high = 1'b1;
        low_run = 0;
      end else begin
        low_run++;
      end
      @(negedge clk);
    end
    cpu.req_valid = 1'b0;
    checks++;
    if (nacc != 4 || nresp != 4)
      begin errors++; $display("FAIL b2b_count got acc %0d resp %0d exp 4 4", nacc, nresp); end
    checks++;
    if (bad_data) begin errors++; $display("FAIL b2b_data got bad %b exp 0", bad_data); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != 5)
        begin errors++; $display("FAIL b2b_spacing%0d got %0d exp 5", i, acc_cyc[i] - acc_cyc[i-1]); end
    end
    checks++;
    if (min_low < 2 || min_low == 1000)
      begin errors++; $display("FAIL b2b_gap got %0d exp >=2", min_low); end
  endtask

  task automatic test_timeout();
    tie_low = 1'b1;
    run_txn(1'b1, 1'b1, 16'h0050, 16'h1111);
    checks++;
    if (t_lat != 15) begin errors++; $display("FAIL timeout_lat got %0d exp 15", t_lat); end
    checks++;
    if (t_err !== 1'b1 || t_rdata !== 16'h0000)
      begin errors++; $display("FAIL timeout_resp got err %b rdata %h exp 1 0000", t_err, t_rdata); end
    checks++;
    if (t_acc != 15 || t_we16 != 15)
      begin errors++; $display("FAIL timeout_access got acc %0d we16 %0d exp 15 15", t_acc, t_we16); end
    checks++;
    if (t_strobes !== 3'b000 || t_again !== 1'b0)
      begin errors++; $display("FAIL timeout_strobes got %b again %b exp 000 0", t_strobes, t_again); end
    tie_low = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    bit resp_seen;
    resp_seen = 1'b0;
    tie_low = 1'b1;
    cpu.req_write = 1'b1; cpu.req_sz = 1'b1; cpu.req_addr = 16'h0040; cpu.req_wdata = 16'hCAFE;
    cpu.req_valid = 1'b1;
    n = 0;
    while (cpu.req_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    cpu.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_we_16 !== 1'b1 || mem_req_rdwr !== 1'b1)
      begin errors++; $display("FAIL rstmid_pre got we16 %b rdwr %b exp 1 1", mem_we_16, mem_req_rdwr); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (mem_we_16 !== 1'b0 || mem_req_rdwr !== 1'b0)
      begin errors++; $display("FAIL rstmid_async got we16 %b rdwr %b exp 0 0", mem_we_16, mem_req_rdwr); end
    repeat (3) begin
      @(negedge clk);
      if (cpu.resp_valid !== 1'b0) resp_seen = 1'b1;
    end
    reset_n = 1'b1;
    tie_low = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (cpu.resp_valid !== 1'b0) resp_seen = 1'b1;
    end
    checks++;
    if (resp_seen) begin errors++; $display("FAIL rstmid_noresp got resp %b exp 0", resp_seen); end
    mem_delay = 2;
    run_txn(1'b0, 1'b0, 16'h0010, 16'h0000);
    checks++;
    if (t_rdata !== 16'h00A5 || t_err !== 1'b0 || t_lat != 3)
      begin errors++; $display("FAIL rstmid_after got %h err %b lat %0d exp 00a5 0 3", t_rdata, t_err, t_lat); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'hA5;
    mem[16'h0031] = 8'h77;
    @(negedge clk);
    test_reset();
    test_read8();
    test_write16_read();
    test_write8();
    test_wrap();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- CPU-side memory transaction controller, directly upstream of the dual-port-backed test memory.
- Accepts one 8-bit or 16-bit read/write request from the CPU core, latches it and drives the memory's req_rdwr / address / write-enable / size inputs.
- Waits for the memory's data_ready, captures read data and returns a one-cycle response.
- Adds a watchdog timeout and guarantees a request-low gap between transactions, because data_ready is registered and phase-dependent.

Parameters:
ADDR_WIDTH, 16, width of cpu address (matches `cpu_addr_width)
TIMEOUT_CYCLES, 15, max cycles spent in ACCESS before error response; legal range 3..255

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  CPU request present
req_ready  out  1  controller can accept (registered, high only in IDLE)
req_write  in  1  1=write, 0=read
req_sz  in  1  access size, pkg_cpu::cpu_data_acc_sz_8 / cpu_data_acc_sz_16
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  16  write data; 8-bit uses [7:0]
resp_valid  out  1  one-cycle response pulse
resp_err  out  1  timeout flag, qualified by resp_valid
resp_rdata  out  16  read data; 8-bit zero-extended; 0 for writes and errors
mem_req_rdwr  out  1  to memory req_rdwr
mem_addr  out  ADDR_WIDTH  to memory addr_in
mem_data_acc_sz  out  1  to memory data_acc_sz
mem_wdata_8  out  8  to memory write_data_in_8
mem_wdata_16  out  16  to memory write_data_in_16
mem_we_8  out  1  to memory write_data_we_8
mem_we_16  out  1  to memory write_data_we_16
mem_rdata_8  in  8  from memory read_data_out_8
mem_rdata_16  in  16  from memory read_data_out_16
mem_data_ready  in  1  from memory data_ready

Behaviour:
- Reset (async assert, sync release): state=SETTLE.
  - All outputs 0, including req_ready, resp_valid, mem_req_rdwr and all mem_we_*.
  - Latched request registers cleared; timeout counter 0.
- FSM states: SETTLE, IDLE, ACCESS, RESP. All outputs are registered.
- SETTLE: mem_req_rdwr=0 for one cycle. This lets the memory's data_ready drop. Next state is IDLE.
- IDLE: req_ready=1.
  - On a rising edge with req_valid=1: latch write, size, address and data.
  - Drive the mem_* outputs from the latched values; mem_req_rdwr=1; req_ready=0; counter=0; go to ACCESS.
  - req_valid without acceptance (any other state) is ignored; the CPU must hold it.
- ACCESS: mem_req_rdwr, mem_addr, mem_data_acc_sz and mem_wdata_* are held stable.
  - mem_we_8 = write & sz8; mem_we_16 = write & sz16. Held high for the whole state; repeated writes of identical data are benign.
  - The counter increments every cycle.
  - mem_data_ready=1 sampled at an edge:
    - Capture resp_rdata: sz16 → mem_rdata_16 = {byte[addr], byte[addr+1]}; sz8 → {8'h00, mem_rdata_8}; write → 0.
    - resp_valid=1, resp_err=0; deassert mem_req_rdwr and all mem_we_*; go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 with no ready: resp_valid=1, resp_err=1, resp_rdata=0; deassert memory strobes; go to RESP.
  - Ready and timeout on the same edge: ready wins, resp_err=0.
- RESP: resp_valid high exactly this one cycle. mem_req_rdwr=0; this is the mandatory request-low gap. Next state is SETTLE, and resp_valid/resp_err return to 0.
- Latency: data_ready comes 1 or 2 edges after req_rdwr rises, depending on memory phase. resp_valid therefore asserts 2 or 3 edges after the accepting edge.
- Minimum spacing between accepting edges is 5 clocks.
- 16-bit addresses wrap: addr 0xFFFF pairs with 0x0000 (memory computes addr+1 modulo 2^ADDR_WIDTH). The controller performs no alignment check.
- Reset mid-ACCESS: strobes drop immediately (async), no response is issued, and the FSM restarts at SETTLE.

Test Plan:
- Reset, then 8-bit read of addr 0x0010 preloaded 0xA5 → req_ready rises 2 edges after release; resp_valid one pulse 2–3 edges after accept; resp_rdata=0x00A5, resp_err=0.
- 16-bit write 0xBEEF to 0x0020, then 16-bit read 0x0020 → read resp_rdata=0xBEEF. A separate 8-bit read of 0x0020 returns 0x00BE, and of 0x0021 returns 0x00EF.
- 8-bit write 0x5A to 0x0030 with req_wdata=0x125A → mem_we_8=1, mem_we_16=0 throughout ACCESS; readback 0x005A; 0x0031 unchanged.
- Back-to-back reads with req_valid held high → accepts exactly 5+ clocks apart; mem_req_rdwr low ≥2 cycles between; no duplicated or lost responses.
- Memory stubbed with mem_data_ready tied 0 → resp_valid with resp_err=1 and resp_rdata=0 after TIMEOUT_CYCLES ACCESS cycles (15); strobes low next cycle.
- Assert reset_n=0 mid-ACCESS of a 16-bit write → mem_we_16 and mem_req_rdwr drop the same cycle; no resp_valid; a later read completes normally.
